// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised array with byte/half/word writes,
// programmable wait states on OKAY transfers and a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter int REGION_BITS = 24
) (
  input  logic                  hclk_i,
  input  logic                  hresetn_i,
  input  logic                  hsel_i,
  input  logic [31:0]           haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  input  logic                  hready_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hready_o,
  output logic                  hresp_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [3:0] LP_LAST_WAIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  state_t                w_accept_state;
  logic [3:0]            r_wait_cnt;
  logic [3:0]            w_wait_cnt_next;
  logic [AW-1:0]         r_word;
  logic                  r_write;
  logic [NB-1:0]         r_be;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic          w_slave_ready;
  logic          w_accept;
  logic          w_size_bad;
  logic          w_align_bad;
  logic          w_region_bad;
  logic          w_legal;
  logic          w_commit;
  logic [NB-1:0] w_be;
  logic          w_unused_bits;

  // Ready depends only on state, so hready_i may be looped back from hready_o.
  assign w_slave_ready = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign hready_o      = w_slave_ready;
  assign hresp_o       = (r_state == S_ERR1) || (r_state == S_ERR2);

  assign w_accept    = hsel_i & hready_i & htrans_i[1] & w_slave_ready;
  assign w_size_bad  = hsize_i > 3'd2;
  assign w_align_bad = ((hsize_i == 3'd1) && haddr_i[0]) ||
                       ((hsize_i == 3'd2) && (haddr_i[1:0] != 2'b00));

  generate
    if (REGION_BITS > AW + 2) begin : g_region
      assign w_region_bad = |haddr_i[REGION_BITS-1:AW+2];
    end else begin : g_no_region
      assign w_region_bad = 1'b0;
    end
    if (REGION_BITS < 32) begin : g_upper
      assign w_unused_bits = ^{haddr_i[31:REGION_BITS], htrans_i[0]};
    end else begin : g_no_upper
      assign w_unused_bits = htrans_i[0];
    end
  endgenerate

  assign w_legal = !(w_size_bad || w_align_bad || w_region_bad);

  always_comb begin
    w_be = '0;
    case (hsize_i[1:0])
      2'd0:    w_be = 4'b0001 << haddr_i[1:0];
      2'd1:    w_be = haddr_i[1] ? 4'b1100 : 4'b0011;
      default: w_be = '1;
    endcase
  end

  always_comb begin
    w_accept_state = S_IDLE;
    if (w_accept) begin
      if (!w_legal)             w_accept_state = S_ERR1;
      else if (WAIT_STATES > 0) w_accept_state = S_WAIT;
      else                      w_accept_state = S_DATA;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_wait_cnt == LP_LAST_WAIT) begin
          w_state_next    = S_DATA;
          w_wait_cnt_next = 4'd0;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 4'd1;
        end
      end
      S_ERR1:  w_state_next = S_ERR2;
      default: begin
        w_state_next    = w_accept_state;
        w_wait_cnt_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_word     <= '0;
      r_write    <= 1'b0;
      r_be       <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_accept) begin
        r_word  <= haddr_i[AW+1:2];
        r_write <= hwrite_i;
        r_be    <= w_be;
      end
    end
  end

  // Writes land at the end of the DATA cycle, so a read accepted in that same
  // cycle sees the new word in its own DATA cycle without any bypass.
  assign w_commit = (r_state == S_DATA) && r_write;

  always_ff @(posedge hclk_i) begin
    if (w_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (r_be[b]) r_mem[r_word][b*8 +: 8] <= hwdata_i[b*8 +: 8];
      end
    end
  end

  assign hrdata_o = ((r_state == S_DATA) && !r_write) ? r_mem[r_word] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 3 wait states) on a shared
// address/data bus, checked each cycle against a transaction-level model.
module tb_ahb_sram_slave;
  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n [N];
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata [N];
  logic        hready [N];
  logic        hresp  [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      ahb_sram_slave #(
        .DATA_WIDTH (32),
        .DEPTH_WORDS(1024),
        .WAIT_STATES((gi == 0) ? 0 : 3),
        .REGION_BITS(24)
      ) u_dut (
        .hclk_i   (clk),
        .hresetn_i(rst_n[gi]),
        .hsel_i   (hsel),
        .haddr_i  (haddr),
        .htrans_i (htrans),
        .hwrite_i (hwrite),
        .hsize_i  (hsize),
        .hwdata_i (hwdata),
        .hready_i (hready[gi]),
        .hrdata_o (hrdata[gi]),
        .hready_o (hready[gi]),
        .hresp_o  (hresp[gi])
      );
    end
  endgenerate

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: one outstanding data phase per instance.
  // kind 0 = none, 1 = OKAY transfer (cnt = stall cycles left), 2 = ERROR (cnt = step)
  int          m_kind [N];
  int          m_cnt  [N];
  bit          m_wr   [N];
  logic [31:0] m_addr [N];
  int          m_size [N];
  logic [31:0] m_mem  [N][1024];

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic bit legal(logic [31:0] a, logic [2:0] s);
    if (s > 3'd2) return 1'b0;
    if ((a % (32'd1 << s)) != 0) return 1'b0;
    if ((a & 32'h00FF_FFFF) >= 32'd4096) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_ready(int k);
    if (!rst_n[k]) return 1'b1;
    if (m_kind[k] == 1) return m_cnt[k] == 0;
    if (m_kind[k] == 2) return m_cnt[k] == 1;
    return 1'b1;
  endfunction

  function automatic bit exp_resp(int k);
    return rst_n[k] && (m_kind[k] == 2);
  endfunction

  function automatic logic [31:0] exp_rdata(int k);
    if (rst_n[k] && m_kind[k] == 1 && m_cnt[k] == 0 && !m_wr[k])
      return m_mem[k][(m_addr[k] & 32'hFFF) >> 2];
    return 32'h0;
  endfunction

  initial begin
    for (int k = 0; k < N; k++) begin
      m_kind[k] = 0;
      m_cnt[k]  = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_n[k]) begin
        m_kind[k] = 0;
      end else if (!exp_ready(k)) begin
        if (m_kind[k] == 1) m_cnt[k] = m_cnt[k] - 1;
        else                m_cnt[k] = 1;
      end else begin
        if (m_kind[k] == 1 && m_wr[k]) begin
          for (int b = 0; b < (1 << m_size[k]); b++) begin
            int lane;
            lane = int'(m_addr[k] % 4) + b;
            m_mem[k][(m_addr[k] & 32'hFFF) >> 2][lane*8 +: 8] = hwdata[lane*8 +: 8];
          end
        end
        if (hsel && htrans[1]) begin
          m_addr[k] = haddr;
          m_wr[k]   = hwrite;
          m_size[k] = int'(hsize);
          if (legal(haddr, hsize)) begin
            m_kind[k] = 1;
            m_cnt[k]  = ws_of(k);
          end else begin
            m_kind[k] = 2;
            m_cnt[k]  = 0;
          end
        end else begin
          m_kind[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      chk($sformatf("cyc_hready_u%0d", k), {31'b0, hready[k]}, {31'b0, exp_ready(k)});
      chk($sformatf("cyc_hresp_u%0d", k), {31'b0, hresp[k]}, {31'b0, exp_resp(k)});
      chk($sformatf("cyc_hrdata_u%0d", k), hrdata[k], exp_rdata(k));
    end
  end

  logic [31:0] x_rdata  [N];
  logic        x_resp   [N];
  int          x_stalls [N];

  // Single non-pipelined transfer; both instances accept it on the same edge.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    bit done [N];
    int cyc;
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; hwdata = wd;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    for (int k = 0; k < N; k++) begin
      done[k] = 1'b0;
      x_stalls[k] = 0;
    end
    cyc = 0;
    while (!(done[0] && done[1]) && cyc < 40) begin
      for (int k = 0; k < N; k++) begin
        if (!done[k]) begin
          if (hready[k]) begin
            done[k]    = 1'b1;
            x_rdata[k] = hrdata[k];
            x_resp[k]  = hresp[k];
          end else begin
            x_stalls[k]++;
          end
        end
      end
      if (!(done[0] && done[1])) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!(done[0] && done[1])) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout addr=%h actual=no_ready required=ready_within_40", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_xfer(input string nm, input logic [31:0] rd, input bit resp, input int st0, input int st1);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_rdata_u%0d", nm, k), x_rdata[k], rd);
      chk($sformatf("%s_resp_u%0d", nm, k), {31'b0, x_resp[k]}, {31'b0, resp});
      chk($sformatf("%s_stalls_u%0d", nm, k), x_stalls[k], (k == 0) ? st0 : st1);
    end
  endtask

  initial begin
    logic [31:0] a;
    int r;
    int pick;
    int word;
    int off;

    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset_hready_u%0d", k), {31'b0, hready[k]}, 32'd1);
      chk($sformatf("reset_hresp_u%0d", k), {31'b0, hresp[k]}, 32'd0);
      chk($sformatf("reset_hrdata_u%0d", k), hrdata[k], 32'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) xfer(1'b1, 32'(i * 4), 3'd2, {16'hC0DE, 16'(i)});
    xfer(1'b1, 32'h0000_0FFC, 3'd2, 32'hC0DE_03FF);

    // Word write then read, latency differs by wait states.
    xfer(1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF);
    expect_xfer("wr_word", 32'h0, 1'b0, 0, 3);
    xfer(1'b0, 32'h0000_0010, 3'd2, 32'h0);
    expect_xfer("rd_word", 32'hDEAD_BEEF, 1'b0, 0, 3);

    // Sub-word writes only touch their lanes.
    xfer(1'b1, 32'h0000_0011, 3'd0, 32'h1234_AA56);
    xfer(1'b1, 32'h0000_0012, 3'd1, 32'h5566_9988);
    xfer(1'b0, 32'h0000_0010, 3'd2, 32'h0);
    expect_xfer("rd_merged", 32'h5566_AAEF, 1'b0, 0, 3);

    // Illegal accesses: two-cycle ERROR, array untouched.
    xfer(1'b1, 32'h0000_0002, 3'd2, 32'hFFFF_FFFF);
    expect_xfer("err_wr_misalign", 32'h0, 1'b1, 1, 1);
    xfer(1'b0, 32'h0000_0002, 3'd2, 32'h0);
    expect_xfer("err_rd_misalign", 32'h0, 1'b1, 1, 1);
    xfer(1'b0, 32'h0000_0000, 3'd2, 32'h0);
    expect_xfer("rd_after_err", 32'hC0DE_0000, 1'b0, 0, 3);
    xfer(1'b0, 32'h0000_1000, 3'd2, 32'h0);
    expect_xfer("err_region", 32'h0, 1'b1, 1, 1);
    xfer(1'b0, 32'h0000_0010, 3'd3, 32'h0);
    expect_xfer("err_size3", 32'h0, 1'b1, 1, 1);
    xfer(1'b0, 32'h0000_0013, 3'd1, 32'h0);
    expect_xfer("err_half_odd", 32'h0, 1'b1, 1, 1);
    xfer(1'b0, 32'hFF00_0010, 3'd2, 32'h0);
    expect_xfer("rd_upper_ignored", 32'h5566_AAEF, 1'b0, 0, 3);
    xfer(1'b0, 32'h0000_0FFC, 3'd2, 32'h0);
    expect_xfer("rd_last_word", 32'hC0DE_03FF, 1'b0, 0, 3);
    xfer(1'b0, 32'h0000_0013, 3'd0, 32'h0);
    expect_xfer("rd_byte_fullword", 32'h5566_AAEF, 1'b0, 0, 3);

    // Reset the wait-state instance in the middle of a write's WAIT phase.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0014; hwrite = 1'b1; hsize = 3'd2;
    hwdata = 32'h1234_5678;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    chk("midreset_hready_u1", {31'b0, hready[1]}, 32'd1);
    chk("midreset_hresp_u1", {31'b0, hresp[1]}, 32'd0);
    chk("midreset_hrdata_u1", hrdata[1], 32'd0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h0000_0014, 3'd2, 32'h0);
    chk("after_reset_rdata_u0", x_rdata[0], 32'h1234_5678);
    chk("after_reset_rdata_u1", x_rdata[1], 32'hC0DE_0005);

    // Randomised pipelined traffic; address phases during stalls must be ignored.
    for (int c = 0; c < 3000; c++) begin
      hsel   = ($urandom_range(0, 3) != 0);
      htrans = 2'($urandom_range(0, 3));
      hwrite = 1'($urandom_range(0, 1));
      r      = int'($urandom_range(0, 15));
      hsize  = (r < 13) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      pick   = int'($urandom_range(0, 16));
      word   = (pick == 16) ? 1023 : pick;
      if ($urandom_range(0, 3) == 0)  off = int'($urandom_range(0, 3));
      else if (hsize == 3'd0)         off = int'($urandom_range(0, 3));
      else if (hsize == 3'd1)         off = 2 * int'($urandom_range(0, 1));
      else                            off = 0;
      a = 32'(word * 4 + off);
      if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(12, 23));
      a = a | (32'($urandom_range(0, 255)) << 24);
      haddr  = a;
      hwdata = $urandom;
      if (c == 1500) begin rst_n[0] = 1'b0; rst_n[1] = 1'b0; end
      if (c == 1502) begin rst_n[0] = 1'b1; rst_n[1] = 1'b1; end
      @(posedge clk); #1;
    end
    hsel = 1'b0; htrans = 2'b00;
    repeat (8) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
